acc_cpu_seq_ctrl: RTL and testbench
===================================

Name: acc_cpu_seq_ctrl

Overview:
- Run/step/load sequencer for the 4-bit accumulator CPU.
- Generates the CPU mode bit (0 = load accumulator from data pins, 1 = execute instruction) and the 4-bit load value.
- Keeps a shadow copy of the CPU program counter, enforces run length, and halts on a breakpoint.
- Sits between the host/test pins and the CPU core.

Parameters:
- PC_W, 4, width of program counter and shadow PC.
- PC_LAST, 5, last program address; PC wraps PC_LAST -> 0.
- CNT_W, 8, width of run-length limit and executed-cycle counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start_i  input  1  run request, level-sampled each cycle.
- stop_i  input  1  halt request.
- step_i  input  1  single-instruction request.
- load_i  input  1  accumulator load request.
- load_data_i  input  4  value to load.
- run_len_i  input  CNT_W  execute-cycle limit per run; 0 = unlimited.
- bp_en_i  input  1  breakpoint enable.
- bp_addr_i  input  PC_W  breakpoint address.
- exec_mode_o  output  1  CPU mode bit; 1 only in RUN/STEP.
- acc_load_o  output  4  value the CPU loads while exec_mode_o = 0.
- pc_o  output  PC_W  shadow PC.
- cycles_o  output  CNT_W  executed cycles in the current run, saturating.
- state_o  output  3  encoded FSM state.
- busy_o  output  1  high in RUN or STEP.
- done_o  output  1  one-cycle pulse when RUN/STEP completes normally.
- bp_hit_o  output  1  one-cycle pulse on breakpoint halt.

Behaviour:
- Reset values: state IDLE; all outputs 0.
- All outputs are registered; exec_mode_o and busy_o decode the current state.
- State encoding: IDLE = 0, LOAD = 1, RUN = 2, STEP = 3, HALT = 4.
- Request priority in a cycle: stop_i > load_i > step_i > start_i.
- IDLE:
  - load_i -> LOAD; acc_load_o <= load_data_i on the same edge.
  - step_i -> STEP.
  - start_i -> RUN; cycles_o <= 0.
  - stop_i is ignored.
- LOAD: lasts exactly 1 cycle, then IDLE. acc_load_o holds its value until the next load.
- RUN: exec_mode_o = 1. Each RUN cycle is one executed instruction:
  - pc_o <= (pc_o == PC_LAST) ? 0 : pc_o + 1.
  - cycles_o <= cycles_o + 1, saturating at all-ones.
- RUN exits (evaluated in the same cycle, on the updated counts):
  - stop_i -> HALT. That cycle still counts as executed. No done_o.
  - run_len_i != 0 and cycles_o + 1 == run_len_i -> HALT; done_o pulses in the first HALT cycle.
  - Breakpoint: see Optional Feature.
  - If stop_i and the length limit hit together: HALT with done_o = 1.
- STEP: exactly one executed cycle (pc_o advances, cycles_o += 1), then HALT with done_o pulse. stop_i in STEP is ignored.
- HALT: exec_mode_o = 0.
  - start_i resumes RUN without clearing cycles_o.
  - step_i -> STEP.
  - load_i -> LOAD.
  - stop_i -> IDLE.
  - A resume whose cycles_o already equals run_len_i runs one cycle and halts again.
- LOAD never changes pc_o (the CPU does not reset PC on load).
- rst_n assertion mid-RUN: immediate return to reset values; no done_o.
- Requests are level-sensitive. A held start_i re-runs from HALT on the cycle after done_o.

Optional Feature:
- Macro: ACC_SEQ_BREAKPOINT_EN.
- Defined: in RUN, if bp_en_i = 1 and the next pc_o value equals bp_addr_i, go to HALT.
  - The instruction at bp_addr_i is not executed.
  - bp_hit_o pulses in the first HALT cycle; done_o stays 0.
  - Resume (start_i) from HALT ignores the breakpoint for the first RUN cycle, so execution can leave the breakpoint address.
  - Breakpoint has priority below stop_i and above the length limit.
- Undefined: bp_en_i and bp_addr_i are ignored; bp_hit_o is tied 0.

Test Plan:
1. Reset, load_i = 1 with load_data_i = 4'hA for 1 cycle -> state LOAD for 1 cycle then IDLE; acc_load_o = 4'hA; exec_mode_o stays 0; pc_o = 0.
2. From IDLE, run_len_i = 3, start_i pulse -> exec_mode_o high exactly 3 cycles; pc_o 0->1->2->3; cycles_o = 3; done_o pulses once; state HALT.
3. run_len_i = 0, start_i, wait 8 cycles, stop_i -> pc_o sequence 1,2,3,4,5,0,1,2 (wrap at 5); halts; done_o = 0; a further stop_i moves HALT->IDLE.
4. In HALT, step_i pulse twice -> one executed cycle each; pc_o +1 each time; done_o pulses after each step; cycles_o increments by 1 per step.
5. stop_i and load_i asserted in the same RUN cycle -> HALT (stop wins); acc_load_o unchanged. Next cycle with load_i -> LOAD.
6. With ACC_SEQ_BREAKPOINT_EN, bp_en_i = 1, bp_addr_i = 4, run_len_i = 0, start at pc 0 -> halt with pc_o = 4, bp_hit_o pulse, done_o = 0. Resume -> pc_o 5, 0, ... continues past 4. Without the macro -> no halt at 4.

Source files
------------

// File: rtl/acc_cpu_seq_ctrl.sv
// acc_cpu_seq_ctrl: run/step/load sequencer for the 4-bit accumulator CPU.
// It drives the CPU mode bit and the accumulator load value.
// It keeps a shadow program counter and an executed-cycle counter.
// It stops a run on a stop request, on the run-length limit, or on a breakpoint.
// Optional feature macro: ACC_SEQ_BREAKPOINT_EN (halt before executing bp_addr_i).
module acc_cpu_seq_ctrl #(
    parameter int PC_W    = 4,
    parameter int PC_LAST = 5,
    parameter int CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic             stop_i,
    input  logic             step_i,
    input  logic             load_i,
    input  logic [3:0]       load_data_i,
    input  logic [CNT_W-1:0] run_len_i,
    input  logic             bp_en_i,
    input  logic [PC_W-1:0]  bp_addr_i,
    output logic             exec_mode_o,
    output logic [3:0]       acc_load_o,
    output logic [PC_W-1:0]  pc_o,
    output logic [CNT_W-1:0] cycles_o,
    output logic [2:0]       state_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             bp_hit_o
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_RUN  = 3'd2,
        S_STEP = 3'd3,
        S_HALT = 3'd4
    } state_t;

    localparam logic [PC_W-1:0] LP_PC_LAST = PC_LAST[PC_W-1:0];

    state_t           r_state;
    state_t           w_stateNext;
    logic [PC_W-1:0]  r_pc;
    logic [CNT_W-1:0] r_cycles;
    logic [3:0]       r_accLoad;
    logic             r_done;
    logic             r_bpHit;

    logic [PC_W-1:0]  w_pcNext;
    logic [CNT_W-1:0] w_cycInc;
    logic             w_lenHit;
    logic             w_bpMatch;
    logic             w_exec;
    logic             w_clrCyc;
    logic             w_doLoad;
    logic             w_done;
    logic             w_bpPulse;
    logic             w_setMask;

    // Next shadow PC wraps from the last program address back to zero.
    // The cycle count saturates at all-ones.
    // Using >= on the limit means a resume that is already at the limit runs one cycle and halts.
    always_comb begin
        w_pcNext = (r_pc == LP_PC_LAST) ? '0 : r_pc + 1'b1;
        w_cycInc = (r_cycles == '1) ? r_cycles : r_cycles + 1'b1;
        w_lenHit = (run_len_i != '0) && (w_cycInc >= run_len_i);
    end

`ifdef ACC_SEQ_BREAKPOINT_EN
    logic r_bpMask;

    // The breakpoint is masked for the first RUN cycle after a resume from HALT.
    // This lets execution leave the breakpoint address.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_bpMask <= 1'b0;
        else        r_bpMask <= w_setMask;
    end

    // A breakpoint matches when the address about to be reached equals bp_addr_i.
    always_comb begin
        w_bpMatch = bp_en_i && !r_bpMask && (w_pcNext == bp_addr_i);
    end
`else
    logic w_unusedBp;

    // Without the feature the breakpoint pins are dead and never match.
    always_comb begin
        w_unusedBp = &{1'b0, bp_en_i, bp_addr_i, w_setMask};
        w_bpMatch  = 1'b0;
    end
`endif

    // Next-state and control decode.
    // Request priority is stop > load > step > start.
    // The order of the if/else chains encodes that priority.
    always_comb begin
        w_stateNext = r_state;
        w_exec      = 1'b0;
        w_clrCyc    = 1'b0;
        w_doLoad    = 1'b0;
        w_done      = 1'b0;
        w_bpPulse   = 1'b0;
        w_setMask   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (load_i) begin
                    w_stateNext = S_LOAD;
                    w_doLoad    = 1'b1;
                end else if (step_i) begin
                    w_stateNext = S_STEP;
                end else if (start_i) begin
                    w_stateNext = S_RUN;
                    w_clrCyc    = 1'b1;
                end
            end
            S_LOAD: begin
                w_stateNext = S_IDLE;
            end
            S_RUN: begin
                w_exec = 1'b1;
                if (stop_i) begin
                    w_stateNext = S_HALT;
                    w_done      = w_lenHit;
                end else if (w_bpMatch) begin
                    w_stateNext = S_HALT;
                    w_bpPulse   = 1'b1;
                end else if (w_lenHit) begin
                    w_stateNext = S_HALT;
                    w_done      = 1'b1;
                end
            end
            S_STEP: begin
                w_exec      = 1'b1;
                w_stateNext = S_HALT;
                w_done      = 1'b1;
            end
            S_HALT: begin
                if (stop_i) begin
                    w_stateNext = S_IDLE;
                end else if (load_i) begin
                    w_stateNext = S_LOAD;
                    w_doLoad    = 1'b1;
                end else if (step_i) begin
                    w_stateNext = S_STEP;
                end else if (start_i) begin
                    w_stateNext = S_RUN;
                    w_setMask   = 1'b1;
                end
            end
            default: begin
                w_stateNext = S_IDLE;
            end
        endcase
    end

    // State, shadow PC, cycle counter, load value and completion pulses.
    // PC and count advance only in executed (RUN/STEP) cycles.
    // A fresh run from IDLE clears the count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_pc      <= '0;
            r_cycles  <= '0;
            r_accLoad <= '0;
            r_done    <= 1'b0;
            r_bpHit   <= 1'b0;
        end else begin
            r_state <= w_stateNext;
            r_done  <= w_done;
            r_bpHit <= w_bpPulse;
            if (w_exec)   r_pc      <= w_pcNext;
            if (w_doLoad) r_accLoad <= load_data_i;
            if (w_clrCyc)    r_cycles <= '0;
            else if (w_exec) r_cycles <= w_cycInc;
        end
    end

    assign state_o     = r_state;
    assign exec_mode_o = (r_state == S_RUN) || (r_state == S_STEP);
    assign busy_o      = (r_state == S_RUN) || (r_state == S_STEP);
    assign acc_load_o  = r_accLoad;
    assign pc_o        = r_pc;
    assign cycles_o    = r_cycles;
    assign done_o      = r_done;
    assign bp_hit_o    = r_bpHit;

endmodule

// File: tb/tb_acc_cpu_seq_ctrl.sv
// tb_acc_cpu_seq_ctrl: scoreboard bench for the accumulator CPU sequencer.
// Each directed vector pushes its hand-computed post-edge snapshot into a queue.
// A monitor pops one snapshot per clock and compares it against the DUT outputs.
module tb_acc_cpu_seq_ctrl;

    localparam logic [3:0] R_NONE  = 4'b0000;
    localparam logic [3:0] R_START = 4'b0001;
    localparam logic [3:0] R_STOP  = 4'b0010;
    localparam logic [3:0] R_STEP  = 4'b0100;
    localparam logic [3:0] R_LOAD  = 4'b1000;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_LOAD = 3'd1;
    localparam logic [2:0] ST_RUN  = 3'd2;
    localparam logic [2:0] ST_STEP = 3'd3;
    localparam logic [2:0] ST_HALT = 3'd4;

    typedef struct packed {
        logic [2:0] st;
        logic [3:0] acc;
        logic [3:0] pc;
        logic [7:0] cyc;
        logic       done;
        logic       bp;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       startReq = 1'b0;
    logic       stopReq = 1'b0;
    logic       stepReq = 1'b0;
    logic       loadReq = 1'b0;
    logic [3:0] loadData = 4'h0;
    logic [7:0] runLen = 8'd0;
    logic       bpEn = 1'b0;
    logic [3:0] bpAddr = 4'd0;

    logic       execMode;
    logic [3:0] accLoad;
    logic [3:0] pcOut;
    logic [7:0] cyclesOut;
    logic [2:0] stateOut;
    logic       busyOut;
    logic       doneOut;
    logic       bpHitOut;

    exp_t expQ[$];
    int   vecCount = 0;
    int   missCount = 0;
    int   vecIndex = 0;

    acc_cpu_seq_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_i     (startReq),
        .stop_i      (stopReq),
        .step_i      (stepReq),
        .load_i      (loadReq),
        .load_data_i (loadData),
        .run_len_i   (runLen),
        .bp_en_i     (bpEn),
        .bp_addr_i   (bpAddr),
        .exec_mode_o (execMode),
        .acc_load_o  (accLoad),
        .pc_o        (pcOut),
        .cycles_o    (cyclesOut),
        .state_o     (stateOut),
        .busy_o      (busyOut),
        .done_o      (doneOut),
        .bp_hit_o    (bpHitOut)
    );

    // Free-running clock, period 10.
    always #5 clk = ~clk;

    // Drive one cycle of requests at the falling edge.
    // Queue the outputs expected after the following rising edge.
    task automatic applyStimulus(input logic [3:0] req, input logic [3:0] data,
                                 input logic [2:0] st, input logic [3:0] acc,
                                 input logic [3:0] pc, input logic [7:0] cyc,
                                 input logic done, input logic bp);
        exp_t e;
        @(negedge clk);
        rst_n    = 1'b1;
        startReq = req[0];
        stopReq  = req[1];
        stepReq  = req[2];
        loadReq  = req[3];
        loadData = data;
        e = '{st: st, acc: acc, pc: pc, cyc: cyc, done: done, bp: bp};
        expQ.push_back(e);
    endtask

    // Assert reset asynchronously for one cycle and expect all-zero outputs.
    task automatic applyReset();
        exp_t e;
        @(negedge clk);
        rst_n    = 1'b0;
        startReq = 1'b0;
        stopReq  = 1'b0;
        stepReq  = 1'b0;
        loadReq  = 1'b0;
        e = '{st: ST_IDLE, acc: 4'h0, pc: 4'h0, cyc: 8'h0, done: 1'b0, bp: 1'b0};
        expQ.push_back(e);
    endtask

    // Compare one expected snapshot with the DUT.
    // The mode bit and busy both follow from the expected state.
    task automatic checkOutput(input exp_t e);
        logic expExec;
        expExec = (e.st == ST_RUN) || (e.st == ST_STEP);
        vecCount++;
        if (stateOut !== e.st || accLoad !== e.acc || pcOut !== e.pc ||
            cyclesOut !== e.cyc || doneOut !== e.done || bpHitOut !== e.bp ||
            execMode !== expExec || busyOut !== expExec) begin
            missCount++;
            $display("[TB] FAIL vec%0d: got st=%0d acc=%h pc=%0d cyc=%0d done=%b bp=%b exec=%b busy=%b, want st=%0d acc=%h pc=%0d cyc=%0d done=%b bp=%b exec=%b busy=%b",
                     vecIndex, stateOut, accLoad, pcOut, cyclesOut, doneOut, bpHitOut,
                     execMode, busyOut, e.st, e.acc, e.pc, e.cyc, e.done, e.bp,
                     expExec, expExec);
        end
        vecIndex++;
    endtask

    // Monitor: sample just after each rising edge and check the oldest pending snapshot.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (expQ.size() > 0) checkOutput(expQ.pop_front());
        end
    end

    // Hard time limit so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL timeout: simulation time limit reached");
        $fatal(1, "[TB] timeout");
    end

    // Directed vectors with hand-computed expectations.
    initial begin
        runLen = 8'd3;
        applyReset();

        // Load 4'hA: one LOAD cycle, then back to IDLE.
        applyStimulus(R_LOAD, 4'hA, ST_LOAD, 4'hA, 4'd0, 8'd0, 1'b0, 1'b0);
        applyStimulus(R_NONE, 4'h0, ST_IDLE, 4'hA, 4'd0, 8'd0, 1'b0, 1'b0);

        // Run of length 3: three RUN cycles, then HALT with a done pulse.
        applyStimulus(R_START, 4'h0, ST_RUN,  4'hA, 4'd0, 8'd0, 1'b0, 1'b0);
        applyStimulus(R_NONE,  4'h0, ST_RUN,  4'hA, 4'd1, 8'd1, 1'b0, 1'b0);
        applyStimulus(R_NONE,  4'h0, ST_RUN,  4'hA, 4'd2, 8'd2, 1'b0, 1'b0);
        applyStimulus(R_NONE,  4'h0, ST_HALT, 4'hA, 4'd3, 8'd3, 1'b1, 1'b0);
        applyStimulus(R_NONE,  4'h0, ST_HALT, 4'hA, 4'd3, 8'd3, 1'b0, 1'b0);

        // Resume with the count already at the limit: one cycle, then HALT again.
        applyStimulus(R_START, 4'h0, ST_RUN,  4'hA, 4'd3, 8'd3, 1'b0, 1'b0);
        applyStimulus(R_NONE,  4'h0, ST_HALT, 4'hA, 4'd4, 8'd4, 1'b1, 1'b0);
        applyStimulus(R_NONE,  4'h0, ST_HALT, 4'hA, 4'd4, 8'd4, 1'b0, 1'b0);

        // Two single steps from HALT; the second wraps the PC from 5 to 0.
        applyStimulus(R_STEP, 4'h0, ST_STEP, 4'hA, 4'd4, 8'd4, 1'b0, 1'b0);
        applyStimulus(R_NONE, 4'h0, ST_HALT, 4'hA, 4'd5, 8'd5, 1'b1, 1'b0);
        applyStimulus(R_STEP, 4'h0, ST_STEP, 4'hA, 4'd5, 8'd5, 1'b0, 1'b0);
        applyStimulus(R_NONE, 4'h0, ST_HALT, 4'hA, 4'd0, 8'd6, 1'b1, 1'b0);
        applyStimulus(R_STOP, 4'h0, ST_IDLE, 4'hA, 4'd0, 8'd6, 1'b0, 1'b0);

        // Unlimited run for 8 cycles with stop on the 8th.
        // The PC goes 1,2,3,4,5,0,1,2 and there is no done pulse.
        runLen = 8'd0;
        applyStimulus(R_START, 4'h0, ST_RUN, 4'hA, 4'd0, 8'd0, 1'b0, 1'b0);
        applyStimulus(R_NONE,  4'h0, ST_RUN, 4'hA, 4'd1, 8'd1, 1'b0, 1'b0);
        applyStimulus(R_NONE,  4'h0, ST_RUN, 4'hA, 4'd2, 8'd2, 1'b0, 1'b0);
        applyStimulus(R_NONE,  4'h0, ST_RUN, 4'hA, 4'd3, 8'd3, 1'b0, 1'b0);
        applyStimulus(R_NONE,  4'h0, ST_RUN, 4'hA, 4'd4, 8'd4, 1'b0, 1'b0);
        applyStimulus(R_NONE,  4'h0, ST_RUN, 4'hA, 4'd5, 8'd5, 1'b0, 1'b0);
        applyStimulus(R_NONE,  4'h0, ST_RUN, 4'hA, 4'd0, 8'd6, 1'b0, 1'b0);
        applyStimulus(R_NONE,  4'h0, ST_RUN, 4'hA, 4'd1, 8'd7, 1'b0, 1'b0);
        applyStimulus(R_STOP,  4'h0, ST_HALT, 4'hA, 4'd2, 8'd8, 1'b0, 1'b0);
        applyStimulus(R_STOP,  4'h0, ST_IDLE, 4'hA, 4'd2, 8'd8, 1'b0, 1'b0);

        // Stop and load in the same RUN cycle: stop wins and the load value is kept.
        // A load on the next cycle then goes to LOAD.
        applyStimulus(R_START,          4'h0, ST_RUN,  4'hA, 4'd2, 8'd0, 1'b0, 1'b0);
        applyStimulus(R_NONE,           4'h0, ST_RUN,  4'hA, 4'd3, 8'd1, 1'b0, 1'b0);
        applyStimulus(R_STOP | R_LOAD,  4'h5, ST_HALT, 4'hA, 4'd4, 8'd2, 1'b0, 1'b0);
        applyStimulus(R_LOAD,           4'h5, ST_LOAD, 4'h5, 4'd4, 8'd2, 1'b0, 1'b0);
        applyStimulus(R_NONE,           4'h0, ST_IDLE, 4'h5, 4'd4, 8'd2, 1'b0, 1'b0);

        // Stop and the length limit in the same cycle: HALT with done.
        runLen = 8'd2;
        applyStimulus(R_START, 4'h0, ST_RUN,  4'h5, 4'd4, 8'd0, 1'b0, 1'b0);
        applyStimulus(R_NONE,  4'h0, ST_RUN,  4'h5, 4'd5, 8'd1, 1'b0, 1'b0);
        applyStimulus(R_STOP,  4'h0, ST_HALT, 4'h5, 4'd0, 8'd2, 1'b1, 1'b0);
        applyStimulus(R_NONE,  4'h0, ST_HALT, 4'h5, 4'd0, 8'd2, 1'b0, 1'b0);

        // In HALT, load beats step and start.
        applyStimulus(R_LOAD | R_STEP | R_START, 4'h3, ST_LOAD, 4'h3, 4'd0, 8'd2, 1'b0, 1'b0);
        applyStimulus(R_NONE, 4'h0, ST_IDLE, 4'h3, 4'd0, 8'd2, 1'b0, 1'b0);

        // In IDLE, step beats start and the count is not cleared.
        // Stop is ignored in STEP and in IDLE.
        runLen = 8'd0;
        applyStimulus(R_STEP | R_START, 4'h0, ST_STEP, 4'h3, 4'd0, 8'd2, 1'b0, 1'b0);
        applyStimulus(R_NONE, 4'h0, ST_HALT, 4'h3, 4'd1, 8'd3, 1'b1, 1'b0);
        applyStimulus(R_STEP, 4'h0, ST_STEP, 4'h3, 4'd1, 8'd3, 1'b0, 1'b0);
        applyStimulus(R_STOP, 4'h0, ST_HALT, 4'h3, 4'd2, 8'd4, 1'b1, 1'b0);
        applyStimulus(R_STOP, 4'h0, ST_IDLE, 4'h3, 4'd2, 8'd4, 1'b0, 1'b0);
        applyStimulus(R_STOP, 4'h0, ST_IDLE, 4'h3, 4'd2, 8'd4, 1'b0, 1'b0);

        // Reset in the middle of a run returns everything to zero with no done.
        applyStimulus(R_START, 4'h0, ST_RUN, 4'h3, 4'd2, 8'd0, 1'b0, 1'b0);
        applyStimulus(R_NONE,  4'h0, ST_RUN, 4'h3, 4'd3, 8'd1, 1'b0, 1'b0);
        applyReset();

        // Breakpoint at address 4 with an unlimited run from PC 0.
        bpEn   = 1'b1;
        bpAddr = 4'd4;
        applyStimulus(R_START, 4'h0, ST_RUN, 4'h0, 4'd0, 8'd0, 1'b0, 1'b0);
        applyStimulus(R_NONE,  4'h0, ST_RUN, 4'h0, 4'd1, 8'd1, 1'b0, 1'b0);
        applyStimulus(R_NONE,  4'h0, ST_RUN, 4'h0, 4'd2, 8'd2, 1'b0, 1'b0);
        applyStimulus(R_NONE,  4'h0, ST_RUN, 4'h0, 4'd3, 8'd3, 1'b0, 1'b0);
`ifdef ACC_SEQ_BREAKPOINT_EN
        applyStimulus(R_NONE,  4'h0, ST_HALT, 4'h0, 4'd4, 8'd4, 1'b0, 1'b1);
        applyStimulus(R_NONE,  4'h0, ST_HALT, 4'h0, 4'd4, 8'd4, 1'b0, 1'b0);
        // Move the breakpoint to 5 before resuming.
        // The first RUN cycle is masked, so execution runs through 5.
        bpAddr = 4'd5;
        applyStimulus(R_START, 4'h0, ST_RUN,  4'h0, 4'd4, 8'd4, 1'b0, 1'b0);
        applyStimulus(R_NONE,  4'h0, ST_RUN,  4'h0, 4'd5, 8'd5, 1'b0, 1'b0);
        applyStimulus(R_NONE,  4'h0, ST_RUN,  4'h0, 4'd0, 8'd6, 1'b0, 1'b0);
        applyStimulus(R_STOP,  4'h0, ST_HALT, 4'h0, 4'd1, 8'd7, 1'b0, 1'b0);
`else
        applyStimulus(R_NONE,  4'h0, ST_RUN,  4'h0, 4'd4, 8'd4, 1'b0, 1'b0);
        applyStimulus(R_NONE,  4'h0, ST_RUN,  4'h0, 4'd5, 8'd5, 1'b0, 1'b0);
        applyStimulus(R_STOP,  4'h0, ST_HALT, 4'h0, 4'd0, 8'd6, 1'b0, 1'b0);
`endif
        applyStimulus(R_NONE, 4'h0, ST_HALT, 4'h0, expQ.size() > 0 ? expQ[$].pc : 4'd0,
                      expQ.size() > 0 ? expQ[$].cyc : 8'd0, 1'b0, 1'b0);

        // Let the monitor drain the queue, within a bounded number of cycles.
        for (int i = 0; i < 5 && expQ.size() > 0; i++) @(posedge clk);
        #2;
        if (expQ.size() > 0) begin
            missCount++;
            $display("[TB] FAIL drain: %0d snapshots left unchecked, want 0", expQ.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
